arc4_prga: RTL and testbench
============================

Name: arc4_prga

Overview:
ARC4 pseudo-random generation stage. Consumes an already key-scheduled 256-byte S-box, a length-prefixed ciphertext memory and a plaintext memory, and decrypts ct into pt. Sits after the KSA stage in the ARC4 decryption datapath. Uses a rdy/en handshake with the top-level controller.

Parameters:
- none; all widths fixed at 8-bit data, 8-bit address, 256-entry memories.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset; synchronous, active-high despite the codebase name (1 = reset)
- en  input  1  start request, honoured only while rdy=1
- rdy  output  1  block idle and able to accept en
- key  input  24  ARC4 key; unused by PRGA, present for interface uniformity
- s_addr  output  8  S-box memory address
- s_rddata  input  8  S-box read data
- s_wrdata  output  8  S-box write data
- s_wren  output  1  S-box write enable
- ct_addr  output  8  ciphertext memory address
- ct_rddata  input  8  ciphertext read data
- pt_addr  output  8  plaintext memory address
- pt_rddata  input  8  plaintext read data (used only with the optional feature)
- pt_wrdata  output  8  plaintext write data
- pt_wren  output  1  plaintext write enable

Behaviour:
- Memories have synchronous read with 1-cycle latency. The FSM inserts one explicit wait state after each address change before sampling rddata.
- Reset: state=IDLE. Internal i, j, k, len, si and sj are 0. All addresses and wrdata are 0. s_wren=0, pt_wren=0, rdy=0 while reset is held. rdy=1 from the first cycle after release.
- Reset mid-operation aborts immediately. No further writes occur, and memory contents written so far remain.
- IDLE: rdy=1. If en=1, latch start and go to LEN_RD. rdy falls the next cycle and stays 0 until return to IDLE. en while rdy=0 is ignored.
- LEN_RD / LEN_WAIT: ct_addr=0. Then len=ct_rddata.
- LEN_WR: pt_addr=0, pt_wrdata=len, pt_wren=1 for one cycle. If len=0, go to IDLE. Otherwise i=0, j=0, k=1.
- RD_I / WAIT_I: i=i+1 mod 256, s_addr=i.
- RD_J / WAIT_J: latch si=s_rddata, then j=j+si mod 256, s_addr=j.
- Latch sj=s_rddata.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1. When i==j both writes occur and the net effect is a no-op.
- RD_PAD / WAIT_PAD: s_addr=(si+sj) mod 256 using the pre-swap values; ct_addr=k.
- WR_PT: pt_addr=k, pt_wrdata=s_rddata XOR ct_rddata, pt_wren=1.
  - If k==len, go to IDLE.
  - Otherwise k=k+1 and go to RD_I.
- All index arithmetic is 8-bit wrap-around. len=255 processes k=1..255 with no overflow of k (compare before increment).
- Write enables are single-cycle pulses, never asserted in IDLE.

Optional Feature:
- Macro PRGA_PT_READBACK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - After each WR_PT, the FSM re-reads pt[k] (address, wait) and compares pt_rddata with the written byte.
  - A mismatch sets err sticky until reset. err is cleared on each new start.
  - Adds two cycles per byte.
- Undefined: no err port, pt_rddata ignored, no readback states.

Decomposition:
- Package arc4_pkg: state enum typedef, byte_t (logic [7:0]), constant LEN_ADDR=8'h00.
- Single module; no sub-module needed. An optional trivial sync-RAM model lives only in the bench.

Test Plan:
- Identity S (s[x]=x), ct={03,00,00,00}, pulse en → pt={03,02,05,07}; S afterwards s[2]=03, s[3]=05, s[5]=02; rdy returns 1.
- Same S, ct={03,FF,FF,FF} → pt={03,FD,FA,F8}.
- ct[0]=00 → only pt[0]=00 written, no s_wren ever asserted, rdy back to 1 within 5 cycles.
- ct[0]=19 (25 bytes) with identity S → exactly 26 pt_wren pulses and 50 s_wren pulses; rdy stays 0 throughout.
- Assert rst_n mid-run at byte 10 → next cycle s_wren=0, pt_wren=0; after release rdy=1. Restart with en completes correctly on a freshly initialised S.
- en held high continuously → exactly one run per IDLE visit. en pulses while busy do not restart or corrupt the run.

Source files
------------

// File: rtl/arc4_pkg.sv
// ARC4 PRGA shared types: FSM state encoding, byte type, length address.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t LEN_ADDR = 8'h00;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WAIT,
    LEN_WR,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    RD_PAD,
    WAIT_PAD,
    WR_PT,
    RB_RD,
    RB_WAIT
  } state_e;

endpackage

// File: rtl/arc4_prga_if.sv
// ARC4 PRGA controller handshake plus S/ct/pt memory buses.
// err exists only when PRGA_PT_READBACK_EN is defined.
interface arc4_prga_if;
  import arc4_pkg::*;

  logic        en;
  logic        rdy;
  logic [23:0] key;
  byte_t       s_addr;
  byte_t       s_rddata;
  byte_t       s_wrdata;
  logic        s_wren;
  byte_t       ct_addr;
  byte_t       ct_rddata;
  byte_t       pt_addr;
  byte_t       pt_rddata;
  byte_t       pt_wrdata;
  logic        pt_wren;
`ifdef PRGA_PT_READBACK_EN
  logic        err;
`endif

  modport master (
`ifdef PRGA_PT_READBACK_EN
    output err,
`endif
    input  en, key,
    input  s_rddata, ct_rddata, pt_rddata,
    output rdy,
    output s_addr, s_wrdata, s_wren,
    output ct_addr,
    output pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
`ifdef PRGA_PT_READBACK_EN
    input  err,
`endif
    output en, key,
    output s_rddata, ct_rddata, pt_rddata,
    input  rdy,
    input  s_addr, s_wrdata, s_wren,
    input  ct_addr,
    input  pt_addr, pt_wrdata, pt_wren
  );

endinterface

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation: decrypts length-prefixed ct into pt.
// Optional PRGA_PT_READBACK_EN re-reads each pt byte and flags err.
module arc4_prga
  import arc4_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  arc4_prga_if.master bus
);

  state_e state_q, state_d;
  byte_t  i_q, i_d;
  byte_t  j_q, j_d;
  byte_t  k_q, k_d;
  byte_t  len_q, len_d;
  byte_t  si_q, si_d;
  byte_t  sj_q, sj_d;
`ifdef PRGA_PT_READBACK_EN
  byte_t  pb_q, pb_d;
  logic   err_q, err_d;
`endif

  logic   rdy_c;
  logic   s_wren_c;
  logic   pt_wren_c;
  byte_t  pt_byte;

  wire unused_in = ^{bus.key, bus.pt_rddata};

  assign pt_byte = bus.s_rddata ^ bus.ct_rddata;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
`ifdef PRGA_PT_READBACK_EN
      pb_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
`ifdef PRGA_PT_READBACK_EN
      pb_q    <= pb_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    len_d         = len_q;
    si_d          = si_q;
    sj_d          = sj_q;
`ifdef PRGA_PT_READBACK_EN
    pb_d          = pb_q;
    err_d         = err_q;
`endif
    rdy_c         = 1'b0;
    s_wren_c      = 1'b0;
    pt_wren_c     = 1'b0;
    bus.s_addr    = '0;
    bus.s_wrdata  = '0;
    bus.ct_addr   = '0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    unique case (state_q)
      IDLE: begin
        rdy_c = 1'b1;
        if (bus.en) begin
          state_d = LEN_RD;
`ifdef PRGA_PT_READBACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      LEN_RD: begin
        bus.ct_addr = LEN_ADDR;
        state_d     = LEN_WAIT;
      end
      LEN_WAIT: begin
        bus.ct_addr = LEN_ADDR;
        len_d       = bus.ct_rddata;
        state_d     = LEN_WR;
      end
      LEN_WR: begin
        bus.pt_addr   = LEN_ADDR;
        bus.pt_wrdata = len_q;
        pt_wren_c     = 1'b1;
        i_d           = '0;
        j_d           = '0;
        k_d           = 8'd1;
        state_d       = (len_q == '0) ? IDLE : RD_I;
      end
      RD_I: begin
        i_d     = i_q + 8'd1;
        state_d = WAIT_I;
      end
      WAIT_I: begin
        bus.s_addr = i_q;
        state_d    = RD_J;
      end
      RD_J: begin
        bus.s_addr = i_q;
        si_d       = bus.s_rddata;
        j_d        = j_q + bus.s_rddata;
        state_d    = WAIT_J;
      end
      WAIT_J: begin
        bus.s_addr = j_q;
        state_d    = WR_I;
      end
      // s[j] is on rddata this cycle; write it straight into s[i]
      WR_I: begin
        sj_d         = bus.s_rddata;
        bus.s_addr   = i_q;
        bus.s_wrdata = bus.s_rddata;
        s_wren_c     = 1'b1;
        state_d      = WR_J;
      end
      WR_J: begin
        bus.s_addr   = j_q;
        bus.s_wrdata = si_q;
        s_wren_c     = 1'b1;
        state_d      = RD_PAD;
      end
      RD_PAD: begin
        bus.s_addr  = si_q + sj_q;
        bus.ct_addr = k_q;
        state_d     = WAIT_PAD;
      end
      WAIT_PAD: begin
        bus.s_addr  = si_q + sj_q;
        bus.ct_addr = k_q;
        state_d     = WR_PT;
      end
      WR_PT: begin
        bus.s_addr    = si_q + sj_q;
        bus.ct_addr   = k_q;
        bus.pt_addr   = k_q;
        bus.pt_wrdata = pt_byte;
        pt_wren_c     = 1'b1;
`ifdef PRGA_PT_READBACK_EN
        pb_d          = pt_byte;
        state_d       = RB_RD;
`else
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_I;
        end
`endif
      end
`ifdef PRGA_PT_READBACK_EN
      RB_RD: begin
        bus.pt_addr = k_q;
        state_d     = RB_WAIT;
      end
      RB_WAIT: begin
        bus.pt_addr = k_q;
        if (bus.pt_rddata != pb_q) err_d = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_I;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // reset gates the strobes at once so an aborted run writes nothing more
  assign bus.rdy     = rdy_c & ~rst_n;
  assign bus.s_wren  = s_wren_c & ~rst_n;
  assign bus.pt_wren = pt_wren_c & ~rst_n;
`ifdef PRGA_PT_READBACK_EN
  assign bus.err     = err_q;
`endif

endmodule

// File: tb/tb_arc4_prga.sv
// Directed bench for arc4_prga with sync-read S/ct/pt memory models.
module tb_arc4_prga;
  import arc4_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  arc4_prga_if bus();

  arc4_prga dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_t s_mem  [256];
  byte_t ct_mem [256];
  byte_t pt_mem [256];
  logic  tb_we;
  int    tb_sel;
  byte_t tb_addr;
  byte_t tb_data;

  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    else if (tb_we && tb_sel == 0) s_mem[tb_addr] <= tb_data;
    if (tb_we && tb_sel == 1) ct_mem[tb_addr] <= tb_data;
    if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    else if (tb_we && tb_sel == 2) pt_mem[tb_addr] <= tb_data;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mem_wr(input int sel, input byte_t a, input byte_t d);
    tb_we   = 1'b1;
    tb_sel  = sel;
    tb_addr = a;
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic init_s();
    for (int x = 0; x < 256; x++) mem_wr(0, byte_t'(x), byte_t'(x));
  endtask

  task automatic set_ct(input byte_t b0, input byte_t b1,
                        input byte_t b2, input byte_t b3);
    mem_wr(1, 8'd0, b0);
    mem_wr(1, 8'd1, b1);
    mem_wr(1, 8'd2, b2);
    mem_wr(1, 8'd3, b3);
  endtask

  task automatic clr_pt(input int n);
    for (int x = 0; x < n; x++) mem_wr(2, byte_t'(x), 8'hEE);
  endtask

  task automatic run_prga(input bit noisy, output int cyc,
                          output int npt, output int ns);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    cyc = 0;
    npt = 0;
    ns  = 0;
    while (cyc < 2000) begin
      if (bus.rdy) break;
      if (bus.pt_wren) npt++;
      if (bus.s_wren) ns++;
      if (noisy) bus.en = cyc[0];
      @(negedge clk);
      cyc++;
    end
    bus.en = 1'b0;
    check("run_done", {31'd0, bus.rdy}, 32'd1);
`ifdef PRGA_PT_READBACK_EN
    check("err_clean", {31'd0, bus.err}, 32'd0);
`endif
  endtask

  int cyc;
  int npt;
  int ns;
  int nr;

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    tb_we   = 1'b0;
    tb_sel  = 0;
    tb_addr = '0;
    tb_data = '0;
    bus.en  = 1'b0;
    bus.key = 24'h0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, bus.rdy}, 32'd0);
    check("rst_swren", {31'd0, bus.s_wren}, 32'd0);
    check("rst_ptwren", {31'd0, bus.pt_wren}, 32'd0);
    check("rst_addrs", {8'd0, bus.s_addr, bus.ct_addr, bus.pt_addr}, 32'd0);
    check("rst_wrdata", {16'd0, bus.s_wrdata, bus.pt_wrdata}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rel_rdy", {31'd0, bus.rdy}, 32'd1);

    init_s();
    set_ct(8'h03, 8'h00, 8'h00, 8'h00);
    clr_pt(5);
    run_prga(1'b0, cyc, npt, ns);
    check("z_pt0", {24'd0, pt_mem[0]}, 32'h03);
    check("z_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("z_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("z_pt3", {24'd0, pt_mem[3]}, 32'h07);
    check("z_pt4", {24'd0, pt_mem[4]}, 32'hEE);
    check("z_s2", {24'd0, s_mem[2]}, 32'h03);
    check("z_s3", {24'd0, s_mem[3]}, 32'h05);
    check("z_s5", {24'd0, s_mem[5]}, 32'h02);
    check("z_npt", npt, 32'd4);
    check("z_ns", ns, 32'd6);

    init_s();
    set_ct(8'h03, 8'hFF, 8'hFF, 8'hFF);
    clr_pt(5);
    run_prga(1'b0, cyc, npt, ns);
    check("f_pt0", {24'd0, pt_mem[0]}, 32'h03);
    check("f_pt1", {24'd0, pt_mem[1]}, 32'hFD);
    check("f_pt2", {24'd0, pt_mem[2]}, 32'hFA);
    check("f_pt3", {24'd0, pt_mem[3]}, 32'hF8);

    set_ct(8'h00, 8'h11, 8'h22, 8'h33);
    clr_pt(2);
    run_prga(1'b0, cyc, npt, ns);
    check("l0_pt0", {24'd0, pt_mem[0]}, 32'h00);
    check("l0_pt1", {24'd0, pt_mem[1]}, 32'hEE);
    check("l0_npt", npt, 32'd1);
    check("l0_ns", ns, 32'd0);
    check("l0_fast", {31'd0, cyc <= 5}, 32'd1);

    init_s();
    set_ct(8'h19, 8'h00, 8'h00, 8'h00);
    run_prga(1'b0, cyc, npt, ns);
    check("l25_npt", npt, 32'd26);
    check("l25_ns", ns, 32'd50);

    init_s();
    clr_pt(12);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    npt = 0;
    cyc = 0;
    while (npt < 10 && cyc < 2000) begin
      if (bus.pt_wren) npt++;
      if (npt < 10) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("mid_reach", npt, 32'd10);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_swren", {31'd0, bus.s_wren}, 32'd0);
    check("mid_ptwren", {31'd0, bus.pt_wren}, 32'd0);
    check("mid_rdy", {31'd0, bus.rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rel_rdy", {31'd0, bus.rdy}, 32'd1);
    check("mid_pt0", {24'd0, pt_mem[0]}, 32'h19);
    check("mid_pt11", {24'd0, pt_mem[11]}, 32'hEE);
    init_s();
    set_ct(8'h03, 8'h00, 8'h00, 8'h00);
    clr_pt(5);
    run_prga(1'b0, cyc, npt, ns);
    check("re_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("re_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("re_pt3", {24'd0, pt_mem[3]}, 32'h07);

    set_ct(8'h00, 8'h00, 8'h00, 8'h00);
    nr  = 0;
    npt = 0;
    bus.en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.rdy) nr++;
      if (bus.pt_wren) npt++;
      @(negedge clk);
    end
    bus.en = 1'b0;
    check("hold_idle", nr, 32'd10);
    check("hold_runs", npt, 32'd10);
    cyc = 0;
    while (!bus.rdy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end

    init_s();
    set_ct(8'h03, 8'h00, 8'h00, 8'h00);
    clr_pt(5);
    run_prga(1'b1, cyc, npt, ns);
    check("nz_npt", npt, 32'd4);
    check("nz_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("nz_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("nz_pt3", {24'd0, pt_mem[3]}, 32'h07);
    repeat (3) @(negedge clk);
    check("nz_idle", {31'd0, bus.rdy}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
